sobel_mod: RTL and testbench
============================

SOBEL_MOD -- requirements
Module: sobel_mod

Interface
REQ-001 SHALL have parameter ROWS, default 400, meaning frame height in pixels (at least 3).
REQ-002 SHALL have parameter COLS, default 400, meaning frame width in pixels (at least 3).
REQ-003 SHALL have port clk, input, 1 bit, system clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset (synchronous, active-high).
REQ-005 SHALL have ports cam_red_i, cam_green_i and cam_blue_i, each input, 8 bits, incoming pixel RGB components.
REQ-006 SHALL have port cam_done_i, input, 1 bit, input-pixel valid; one pixel is accepted per rising edge while it is high.
REQ-007 SHALL have ports cam_red_o, cam_green_o and cam_blue_o, each output, 8 bits, Sobel magnitude; all three carry the same value.
REQ-008 SHALL have port sobel_done_o, output, 1 bit, output-pixel valid; outputs are sampled by the consumer on every cycle it is high.

Function
REQ-009 SHALL accept pixels in raster order (row 0 col 0 first, cols fastest), ROWS*COLS pixels per frame, tracking row and col counters; gaps (cam_done_i low) allowed anywhere.
REQ-010 SHALL convert each accepted pixel to gray = (77*R + 150*G + 29*B) >> 8, with a 16-bit unsigned intermediate and an 8-bit result (max 255).
REQ-011 SHALL store gray values in two COLS-deep line buffers plus shift registers, forming a 3x3 window p[r][c] centred on pixel index p = i-COLS-1 when input index i is accepted.
REQ-012 SHALL compute Gx = (p02+2*p12+p22) - (p00+2*p10+p20) and Gy = (p20+2*p21+p22) - (p00+2*p01+p02), where the first index is the window row, top to bottom, and the second is the window column, left to right; each SHALL be signed 11-bit.
REQ-013 SHALL output mag = |Gx|+|Gy|, saturated to 255.
REQ-014 SHALL force output 0 for border pixels: row 0, row ROWS-1, col 0, or col COLS-1.
REQ-015 SHALL emit exactly ROWS*COLS outputs per frame, in raster order, one per valid cycle.
REQ-016 SHALL assert output p for one cycle, 2 clock cycles after the edge that accepted input p+COLS+1 (gray register, then Sobel/output register).
REQ-017 SHALL flush once the ROWS*COLS-th input is accepted: the remaining COLS+1 outputs, all border pixels and therefore 0, back-to-back on consecutive cycles with no further input.
REQ-018 SHALL ignore cam_done_i during the flush.
REQ-019 SHALL return all counters to 0 after the last output of a frame, ready for the next frame.
REQ-020 SHALL deassert sobel_done_o and hold the RGB outputs at their last value on cycles with no output.

Reset
REQ-021 SHALL, when rst is sampled high, clear the row, col and output counters, the flush flag and the pipeline valid bits, and drive sobel_done_o=0 and all RGB outputs 0 on the following cycle.
REQ-022 SHALL not require the line buffer contents to be cleared by reset.
REQ-023 SHALL abandon a partial frame on reset mid-frame; the next accepted pixel is row 0 col 0.
REQ-024 SHALL ignore cam_done_i in any cycle where rst is high.

Verification
REQ-025 With ROWS=COLS=4, 16 pixels R=G=B=100, the bench SHALL require gray 100, 16 outputs and all outputs 0.
REQ-026 With ROWS=COLS=4, cols 0-1 at 0 and cols 2-3 at 255 (R=G=B), the bench SHALL require pixels (1,1), (1,2), (2,1) and (2,2) to be 255, saturated from 1020, and all others 0.
REQ-027 With ROWS=COLS=5 and gray = 10*col (R=G=B), the bench SHALL require every interior output to be 80 and every border output 0.
REQ-028 With ROWS=COLS=4 and 16 pixels fed continuously, the bench SHALL require the 11th output (index 10) to appear 2 cycles after input 15 is accepted, followed by 5 flush outputs of 0 on consecutive cycles and then sobel_done_o low.
REQ-029 With ROWS=COLS=4, gaps inserted on cam_done_i, and rst pulsed after 7 pixels before a full frame, the bench SHALL require values identical to the gap-free, reset-free run and exactly 16 outputs after the reset.
REQ-030 With ROWS=COLS=4, two frames fed back-to-back after the flush, the bench SHALL require 32 outputs total and frame 2 to be independent of frame 1.

Source files
------------

// File: rtl/sobel_mod.sv
// Streaming Sobel edge detector: RGB -> gray, 3x3 window from two line buffers,
// |Gx|+|Gy| magnitude saturated to 8 bits, border pixels forced to zero.
module sobel_mod #(
  parameter int ROWS = 400,
  parameter int COLS = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cam_red_i,
  input  logic [7:0] cam_green_i,
  input  logic [7:0] cam_blue_i,
  input  logic       cam_done_i,
  output logic [7:0] cam_red_o,
  output logic [7:0] cam_green_o,
  output logic [7:0] cam_blue_o,
  output logic       sobel_done_o
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int PIX = ROWS * COLS;
  localparam int PW  = $clog2(PIX + COLS + 1);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW:0]   FL_LAST  = (CW + 1)'(COLS);
  localparam logic [PW-1:0] PRIMED   = PW'(COLS + 1);
  localparam logic [PW-1:0] PUSH_END = PW'(PIX + COLS);

  // input side
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          flush;
  logic [CW:0]   fcnt;
  logic          push;
  logic [15:0]   gsum;

  // gray register stage
  logic          v1;
  logic [7:0]    gray_q;
  logic [CW-1:0] pcol;

  // window stage
  logic [7:0]    lb1 [0:COLS-1];
  logic [7:0]    lb2 [0:COLS-1];
  logic [7:0]    win [0:2][0:2];
  logic [PW-1:0] pcnt;
  logic          v2;

  // output stage
  logic [RW-1:0] orow;
  logic [CW-1:0] ocol;
  logic [10:0]   gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx, gy;
  logic [10:0]   ax, ay;
  logic [11:0]   msum;
  logic [7:0]    mag;
  logic          border;

  assign push = flush | cam_done_i;
  assign gsum = 16'd77  * {8'd0, cam_red_i}
              + 16'd150 * {8'd0, cam_green_i}
              + 16'd29  * {8'd0, cam_blue_i};

  // Flush pushes COLS+1 zero pseudo-pixels so the last row drains without input.
  always_ff @(posedge clk) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      flush  <= 1'b0;
      fcnt   <= '0;
      v1     <= 1'b0;
      gray_q <= '0;
      pcol   <= '0;
    end else begin
      v1 <= push;
      if (push) begin
        gray_q <= flush ? 8'd0 : 8'(gsum >> 8);
        pcol   <= col;
        if (flush) begin
          if (fcnt == FL_LAST) begin
            flush <= 1'b0;
            fcnt  <= '0;
            col   <= '0;
            row   <= '0;
          end else begin
            fcnt <= fcnt + 1'b1;
            col  <= (col == COL_LAST) ? '0 : col + 1'b1;
          end
        end else if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row   <= '0;
            flush <= 1'b1;
            fcnt  <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffers and window carry no reset; stale data only reaches border outputs.
  always_ff @(posedge clk) begin
    if (v1) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2]  <= lb2[pcol];
      win[1][2]  <= lb1[pcol];
      win[2][2]  <= gray_q;
      lb2[pcol]  <= lb1[pcol];
      lb1[pcol]  <= gray_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      v2   <= 1'b0;
    end else begin
      v2 <= v1 && (pcnt >= PRIMED);
      if (v1)
        pcnt <= (pcnt == PUSH_END) ? '0 : pcnt + 1'b1;
    end
  end

  always_comb begin
    gx_pos = 11'(win[0][2]) + {2'b0, win[1][2], 1'b0} + 11'(win[2][2]);
    gx_neg = 11'(win[0][0]) + {2'b0, win[1][0], 1'b0} + 11'(win[2][0]);
    gy_pos = 11'(win[2][0]) + {2'b0, win[2][1], 1'b0} + 11'(win[2][2]);
    gy_neg = 11'(win[0][0]) + {2'b0, win[0][1], 1'b0} + 11'(win[0][2]);
    gx     = $signed(gx_pos - gx_neg);
    gy     = $signed(gy_pos - gy_neg);
    ax     = gx[10] ? (11'd0 - $unsigned(gx)) : $unsigned(gx);
    ay     = gy[10] ? (11'd0 - $unsigned(gy)) : $unsigned(gy);
    msum   = {1'b0, ax} + {1'b0, ay};
    mag    = (msum > 12'd255) ? 8'hFF : msum[7:0];
    border = (orow == '0) || (orow == ROW_LAST) || (ocol == '0) || (ocol == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sobel_done_o <= 1'b0;
      cam_red_o    <= '0;
      cam_green_o  <= '0;
      cam_blue_o   <= '0;
      orow         <= '0;
      ocol         <= '0;
    end else begin
      sobel_done_o <= v2;
      if (v2) begin
        cam_red_o   <= border ? 8'd0 : mag;
        cam_green_o <= border ? 8'd0 : mag;
        cam_blue_o  <= border ? 8'd0 : mag;
        if (ocol == COL_LAST) begin
          ocol <= '0;
          orow <= (orow == ROW_LAST) ? '0 : orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_mod.sv
// Directed bench for sobel_mod: 4x4 and 5x5 instances checked against a
// frame-level Sobel model, with latency, flush, reset and back-to-back frames.
module tb_sobel_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] red, green, blue;
  logic       done4, done5;
  logic [7:0] r4, g4, b4, r5, g5, b5;
  logic       sd4, sd5;

  sobel_mod #(.ROWS(4), .COLS(4)) u4 (
    .clk(clk), .rst(rst),
    .cam_red_i(red), .cam_green_i(green), .cam_blue_i(blue), .cam_done_i(done4),
    .cam_red_o(r4), .cam_green_o(g4), .cam_blue_o(b4), .sobel_done_o(sd4)
  );

  sobel_mod #(.ROWS(5), .COLS(5)) u5 (
    .clk(clk), .rst(rst),
    .cam_red_i(red), .cam_green_i(green), .cam_blue_i(blue), .cam_done_i(done5),
    .cam_red_o(r5), .cam_green_o(g5), .cam_blue_o(b5), .sobel_done_o(sd5)
  );

  int checks = 0;
  int errors = 0;

  int img_r [0:24];
  int img_g [0:24];
  int img_b [0:24];

  // expectation stores: main writes wr*, compare process owns rd*
  int exp4 [0:255];
  int exp5 [0:255];
  int wr4 = 0, wr5 = 0;
  int rd4 = 0, rd5 = 0;
  int n4 = 0, n5 = 0;
  int last4 = 0, last5 = 0;
  int out_cyc4 [0:255];
  int ncyc = 0;
  logic rst_q = 1'b0;
  int acc = 0;

  always @(posedge clk) begin
    ncyc  <= ncyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic int gray_of(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b) >> 8;
  endfunction

  function automatic int gpix(input int n, input int r, input int c);
    int k;
    k = r * n + c;
    return gray_of(img_r[k], img_g[k], img_b[k]);
  endfunction

  function automatic int ref_pix(input int n, input int r, input int c);
    int gxv, gyv, m;
    if (r == 0 || r == n - 1 || c == 0 || c == n - 1) return 0;
    gxv = (gpix(n, r-1, c+1) + 2*gpix(n, r, c+1) + gpix(n, r+1, c+1))
        - (gpix(n, r-1, c-1) + 2*gpix(n, r, c-1) + gpix(n, r+1, c-1));
    gyv = (gpix(n, r+1, c-1) + 2*gpix(n, r+1, c) + gpix(n, r+1, c+1))
        - (gpix(n, r-1, c-1) + 2*gpix(n, r-1, c) + gpix(n, r-1, c+1));
    m = (gxv < 0 ? -gxv : gxv) + (gyv < 0 ? -gyv : gyv);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic set_img(input int n, input int kind);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        int k, v;
        k = r * n + c;
        case (kind)
          0: v = 100;
          1: v = (c < 2) ? 0 : 255;
          2: v = 10 * c;
          default: v = -1;
        endcase
        if (v < 0) begin
          img_r[k] = $urandom_range(0, 255);
          img_g[k] = $urandom_range(0, 255);
          img_b[k] = $urandom_range(0, 255);
        end else begin
          img_r[k] = v; img_g[k] = v; img_b[k] = v;
        end
      end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      done4 = 1'b0; done5 = 1'b0;
      red = 8'($urandom_range(0, 255));
    end
  endtask

  // Tail keeps cam_done_i high with junk data across the flush window.
  task automatic feed(input int n, input int npix, input int gaps, input int tail);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (n == 4) begin exp4[wr4] = ref_pix(4, r, c); wr4++; end
        else        begin exp5[wr5] = ref_pix(5, r, c); wr5++; end
    for (int p = 0; p < npix; p++) begin
      if (gaps != 0) idle($urandom_range(0, 2));
      @(negedge clk);
      red = 8'(img_r[p]); green = 8'(img_g[p]); blue = 8'(img_b[p]);
      done4 = (n == 4); done5 = (n == 5);
      if (p == n * n - 1) acc = ncyc + 1;
    end
    if (tail != 0)
      repeat (n + 1) begin
        @(negedge clk);
        red = 8'($urandom_range(0, 255)); green = 8'($urandom_range(0, 255));
        blue = 8'($urandom_range(0, 255));
      end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        check("rst_done4", int'(sd4), 0);
        check("rst_rgb4", int'(r4) + int'(g4) + int'(b4), 0);
        check("rst_done5", int'(sd5), 0);
        check("rst_rgb5", int'(r5) + int'(g5) + int'(b5), 0);
        last4 = 0; last5 = 0;
        rd4 = wr4; rd5 = wr5;
      end else begin
        if (sd4) begin
          if (rd4 >= wr4) check("unexpected_out4", int'(sd4), 0);
          else begin
            check("pix4_r", int'(r4), exp4[rd4]);
            check("pix4_g", int'(g4), exp4[rd4]);
            check("pix4_b", int'(b4), exp4[rd4]);
            last4 = exp4[rd4];
            rd4++;
          end
          out_cyc4[n4 % 256] = ncyc;
          n4++;
        end else check("hold4", int'(r4), last4);
        if (sd5) begin
          if (rd5 >= wr5) check("unexpected_out5", int'(sd5), 0);
          else begin
            check("pix5_r", int'(r5), exp5[rd5]);
            check("pix5_g", int'(g5), exp5[rd5]);
            check("pix5_b", int'(b5), exp5[rd5]);
            last5 = exp5[rd5];
            rd5++;
          end
          n5++;
        end else check("hold5", int'(r5), last5);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; done4 = 1'b0; done5 = 1'b0;
    red = '0; green = '0; blue = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("model_gray_100", gray_of(100, 100, 100), 100);
    check("model_gray_red", gray_of(255, 0, 0), 76);
    set_img(4, 1);
    check("model_stripe_11", ref_pix(4, 1, 1), 255);
    check("model_stripe_22", ref_pix(4, 2, 2), 255);
    check("model_stripe_10", ref_pix(4, 1, 0), 0);
    set_img(5, 2);
    check("model_ramp_22", ref_pix(5, 2, 2), 80);
    check("model_ramp_04", ref_pix(5, 0, 4), 0);

    // flat frame, latency and flush timing
    set_img(4, 0);
    base = n4;
    feed(4, 16, 0, 1);
    idle(6);
    check("count_flat", n4 - base, 16);
    check("lat_out10", out_cyc4[base + 10], acc + 2);
    for (int k = 1; k <= 5; k++)
      check("flush_cycle", out_cyc4[base + 10 + k], acc + 2 + k);

    // vertical edge stripes
    set_img(4, 1);
    base = n4;
    feed(4, 16, 0, 1);
    idle(6);
    check("count_stripe", n4 - base, 16);

    // partial frame abandoned by reset, then gapped frame
    set_img(4, 3);
    base = n4;
    feed(4, 7, 0, 0);
    idle(4);
    check("count_partial", n4 - base, 2);
    @(negedge clk); rst = 1'b1; done4 = 1'b1;
    @(negedge clk); rst = 1'b0; done4 = 1'b0;
    @(negedge clk);
    base = n4;
    feed(4, 16, 1, 1);
    idle(6);
    check("count_after_rst", n4 - base, 16);

    // back-to-back frames
    base = n4;
    set_img(4, 3);
    feed(4, 16, 0, 1);
    set_img(4, 2);
    feed(4, 16, 0, 1);
    idle(8);
    check("count_b2b", n4 - base, 32);

    // 5x5 ramp with gaps
    set_img(5, 2);
    base = n5;
    feed(5, 25, 1, 1);
    idle(8);
    check("count_ramp5", n5 - base, 25);

    check("pending4", wr4 - rd4, 0);
    check("pending5", wr5 - rd5, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
